// File: rtl/gate_bist_pkg.sv
// Shared definitions for the 2-input gate BIST sequencer.
//   state_e : sequencer states (IDLE, APPLY, CHECK, DONE)
//   TT_*    : expected truth tables; bit idx = expected y for {a,b} = idx
package gate_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;

endpackage

// File: rtl/gate_bist_settle_timer.sv
// Settle-window down-counter for the gate BIST sequencer.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   load_i      : load SETTLE_CYC-1 (asserted on the edge that enters APPLY)
//   en_i        : count down while high, stopping at 0
//   expire_o    : counter is at 0, settle window is over
module gate_bist_settle_timer #(
    parameter int SETTLE_CYC = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = CW'(SETTLE_CYC - 1);
        else if (en_i && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/gate_bist_ctrl.sv
// Built-in-test sequencer for a 2-input logic gate. Drives the four {a,b}
// patterns, holds each for SETTLE_CYC cycles, samples dut_y in a CHECK cycle
// and counts mismatches against a latched truth table (saturating counter).
// Ports:
//   clk, rst_n     : clock, async active-low reset
//   start          : begin a run (accepted in IDLE or DONE only)
//   truth_tbl[3:0] : expected outputs, latched on accepted start
//   dut_a, dut_b   : gate stimulus
//   dut_y          : gate output under test (synchronous to clk)
//   busy, done     : run in progress / run finished
//   pass           : valid while done, 1 iff err_cnt == 0
//   err_cnt        : mismatch count, saturating at 2**ERR_W-1
//   fail_idx[1:0]  : first failing {a,b} index (GATE_BIST_STOP_ON_FAIL_EN only)
// Build option GATE_BIST_STOP_ON_FAIL_EN: the first mismatch ends the run.
module gate_bist_ctrl
    import gate_bist_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter int LOOPS      = 1,
    parameter int ERR_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       truth_tbl,
    output logic             dut_a,
    output logic             dut_b,
    input  logic             dut_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt
`ifdef GATE_BIST_STOP_ON_FAIL_EN
    ,
    output logic [1:0]       fail_idx
`endif
);

    localparam int               LW      = (LOOPS > 1) ? $clog2(LOOPS) : 1;
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    state_e           state_q, state_d;
    logic [3:0]       tt_q, tt_d;
    logic [1:0]       idx_q, idx_d;
    logic [LW-1:0]    loop_q, loop_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             expire;
    logic             mismatch;
`ifdef GATE_BIST_STOP_ON_FAIL_EN
    logic [1:0]       fail_q, fail_d;
`endif

    // Reload the settle window on every entry into APPLY.
    gate_bist_settle_timer #(.SETTLE_CYC(SETTLE_CYC)) u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (state_d == APPLY && state_q != APPLY),
        .en_i     (state_q == APPLY),
        .expire_o (expire)
    );

    assign mismatch = (dut_y != tt_q[idx_q]);

    always_comb begin
        state_d = state_q;
        tt_d    = tt_q;
        idx_d   = idx_q;
        loop_d  = loop_q;
        err_d   = err_q;
`ifdef GATE_BIST_STOP_ON_FAIL_EN
        fail_d  = fail_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = APPLY;
                    tt_d    = truth_tbl;
                    idx_d   = 2'd0;
                    loop_d  = '0;
                    err_d   = '0;
`ifdef GATE_BIST_STOP_ON_FAIL_EN
                    fail_d  = 2'd0;
`endif
                end
            end
            APPLY: begin
                if (expire) state_d = CHECK;
            end
            CHECK: begin
                if (mismatch && err_q != ERR_MAX) err_d = err_q + 1'b1;
`ifdef GATE_BIST_STOP_ON_FAIL_EN
                if (mismatch) begin
                    state_d = DONE;
                    fail_d  = idx_q;
                end else
`endif
                if (idx_q != 2'd3) begin
                    idx_d   = idx_q + 2'd1;
                    state_d = APPLY;
                end else if (int'(loop_q) < LOOPS - 1) begin
                    idx_d   = 2'd0;
                    loop_d  = loop_q + 1'b1;
                    state_d = APPLY;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tt_q    <= '0;
            idx_q   <= '0;
            loop_q  <= '0;
            err_q   <= '0;
`ifdef GATE_BIST_STOP_ON_FAIL_EN
            fail_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            tt_q    <= tt_d;
            idx_q   <= idx_d;
            loop_q  <= loop_d;
            err_q   <= err_d;
`ifdef GATE_BIST_STOP_ON_FAIL_EN
            fail_q  <= fail_d;
`endif
        end
    end

    // Stimulus is forced to 00 outside a run so the gate sees a quiet input.
    assign busy    = (state_q == APPLY) || (state_q == CHECK);
    assign done    = (state_q == DONE);
    assign pass    = done && (err_q == '0);
    assign dut_a   = busy & idx_q[1];
    assign dut_b   = busy & idx_q[0];
    assign err_cnt = err_q;
`ifdef GATE_BIST_STOP_ON_FAIL_EN
    assign fail_idx = fail_q;
`endif

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Directed bench for gate_bist_ctrl: default instance plus a LOOPS=3/ERR_W=3
// instance whose gate output is stuck at 1.
module tb_gate_bist_ctrl;
    import gate_bist_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       start_s = 1'b0;
    logic [3:0] tt = TT_AND;
    int         gate = 0;   // 0 AND, 1 OR, 2 XOR, other: stuck at 1

    logic       a, b, y, busy, done, pass;
    logic [3:0] err;
    logic       a_s, b_s, busy_s, done_s, pass_s;
    logic [2:0] err_s;
`ifdef GATE_BIST_STOP_ON_FAIL_EN
    logic [1:0] fidx, fidx_s;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    always_comb begin
        case (gate)
            0:       y = a & b;
            1:       y = a | b;
            2:       y = a ^ b;
            default: y = 1'b1;
        endcase
    end

    gate_bist_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .truth_tbl(tt),
        .dut_a(a), .dut_b(b), .dut_y(y),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err)
`ifdef GATE_BIST_STOP_ON_FAIL_EN
        , .fail_idx(fidx)
`endif
    );

    gate_bist_ctrl #(.SETTLE_CYC(2), .LOOPS(3), .ERR_W(3)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start_s), .truth_tbl(tt),
        .dut_a(a_s), .dut_b(b_s), .dut_y(1'b1),
        .busy(busy_s), .done(done_s), .pass(pass_s), .err_cnt(err_s)
`ifdef GATE_BIST_STOP_ON_FAIL_EN
        , .fail_idx(fidx_s)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves the bench 1ns after the edge that sampled start (sample 0).
    task automatic do_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        // reset state
        tick(2);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err, 0);
        chk("rst_ab", {a, b}, 0);
        #2 rst_n = 1'b1;
        tick(2);
        chk("idle_busy", busy, 0);

        // good AND gate: 12 busy cycles, patterns 00,01,10,11 held 3 each
        gate = 0; tt = TT_AND;
        do_start();
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("and_busy%0d", i), busy, 1);
            chk($sformatf("and_ab%0d", i), {a, b}, i / 3);
            chk($sformatf("and_done%0d", i), done, 0);
            tick(1);
        end
        chk("and_done", done, 1);
        chk("and_pass", pass, 1);
        chk("and_err", err, 0);
        chk("and_busy_end", busy, 0);
        chk("and_ab_end", {a, b}, 0);

        // OR gate against AND table, started from DONE
        gate = 1;
        do_start();
        chk("or_done_drop", done, 0);
        chk("or_pass_drop", pass, 0);
        chk("or_busy", busy, 1);
        tick(12);
        chk("or_done", done, 1);
        chk("or_pass", pass, 0);
`ifdef GATE_BIST_STOP_ON_FAIL_EN
        chk("or_err", err, 1);
`else
        chk("or_err", err, 2);
`endif

        // start while busy and truth table change mid-run are ignored
        gate = 0;
        do_start();
        tick(4);
        tt = TT_OR;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(6);
        chk("ign_busy11", busy, 1);
        chk("ign_done11", done, 0);
        tick(1);
        chk("ign_done", done, 1);
        chk("ign_pass", pass, 1);
        chk("ign_err", err, 0);

        // reset during CHECK of idx 2
        gate = 1; tt = TT_AND;
        do_start();
        tick(8);
        chk("mid_err", err, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_pass", pass, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_ab", {a, b}, 0);
        #2 rst_n = 1'b1;
        gate = 0;
        tick(1);
        do_start();
        tick(12);
        chk("fresh_done", done, 1);
        chk("fresh_pass", pass, 1);
        chk("fresh_err", err, 0);

`ifdef GATE_BIST_STOP_ON_FAIL_EN
        // stop on first failure: XOR vs AND fails at idx 1
        gate = 2; tt = TT_AND;
        do_start();
        tick(5);
        chk("stop_busy", busy, 1);
        tick(1);
        chk("stop_done", done, 1);
        chk("stop_err", err, 1);
        chk("stop_fidx", fidx, 1);
        chk("stop_pass", pass, 0);
        chk("stop_ab", {a, b}, 0);
`else
        // stuck-at-1 against AND table, 3 loops: 9 mismatches saturate at 7
        tt = TT_AND;
        start_s = 1'b1;
        tick(1);
        start_s = 1'b0;
        tick(24);
        chk("sat_err_mid", err_s, 6);
        chk("sat_busy_mid", busy_s, 1);
        tick(11);
        chk("sat_busy_end", busy_s, 1);
        tick(1);
        chk("sat_done", done_s, 1);
        chk("sat_err", err_s, 7);
        chk("sat_pass", pass_s, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
